// File: rtl/mii_tx_framer.sv
// Transmit-side MII framer: byte stream in, nibble-wide Ethernet frame out
// (preamble/SFD, payload, zero pad, CRC32 FCS, inter-packet gap).
module mii_tx_framer #(
  parameter int MIN_PAYLOAD = 60,
  parameter int MAX_PAYLOAD = 1514,
  parameter int IPG_CYCLES  = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] txd,
  output logic       txen,
  output logic       txer,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, PAYLOAD, PAD, FCS, ABORT, DRAIN, IPG
  } state_t;

  localparam logic [15:0] MIN_CNT  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IPG_LAST = 16'(IPG_CYCLES - 1);
  localparam state_t      POST_FRAME = (IPG_CYCLES == 0) ? IDLE : IPG;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] byte_cnt, byte_cnt_nx;
  logic        hi, hi_nx;
  logic [7:0]  data_q, data_nx;
  logic        last_q, last_nx;
  logic [31:0] crc, crc_nx;

  logic [3:0]  txd_nx;
  logic        txen_nx, txer_nx, in_ready_nx, busy_nx, done_nx, err_nx;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'd0, d};
    for (int unsigned i = 0; i < 4; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      byte_cnt   <= '0;
      hi         <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      crc        <= '1;
      txd        <= '0;
      txen       <= 1'b0;
      txer       <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      byte_cnt   <= byte_cnt_nx;
      hi         <= hi_nx;
      data_q     <= data_nx;
      last_q     <= last_nx;
      crc        <= crc_nx;
      txd        <= txd_nx;
      txen       <= txen_nx;
      txer       <= txer_nx;
      in_ready   <= in_ready_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
      frame_err  <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    byte_cnt_nx = byte_cnt;
    hi_nx       = hi;
    data_nx     = data_q;
    last_nx     = last_q;
    crc_nx      = crc;
    done_nx     = 1'b0;
    err_nx      = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx    = PREAMBLE;
          cnt_nx      = '0;
          byte_cnt_nx = '0;
          hi_nx       = 1'b0;
          last_nx     = 1'b0;
          crc_nx      = '1;
        end
      end

      PREAMBLE: begin
        if (cnt == 16'd15) begin
          if (in_valid) begin
            state_nx    = PAYLOAD;
            data_nx     = in_data;
            last_nx     = in_last;
            byte_cnt_nx = 16'd1;
            hi_nx       = 1'b0;
          end else begin
            state_nx = ABORT;
            cnt_nx   = '0;
            err_nx   = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      PAYLOAD: begin
        if (!hi) begin
          crc_nx = crc_nib(crc, data_q[3:0]);
          hi_nx  = 1'b1;
        end else begin
          crc_nx = crc_nib(crc, data_q[7:4]);
          hi_nx  = 1'b0;
          // in_ready was high this cycle only on the final branch below
          if (last_q) begin
            cnt_nx   = '0;
            state_nx = (byte_cnt < MIN_CNT) ? PAD : FCS;
          end else if (byte_cnt == MAX_CNT || !in_valid) begin
            state_nx = ABORT;
            cnt_nx   = '0;
            err_nx   = 1'b1;
          end else begin
            data_nx     = in_data;
            last_nx     = in_last;
            byte_cnt_nx = byte_cnt + 16'd1;
          end
        end
      end

      PAD: begin
        crc_nx = crc_nib(crc, 4'h0);
        hi_nx  = !hi;
        if (hi) begin
          byte_cnt_nx = byte_cnt + 16'd1;
          if (byte_cnt + 16'd1 >= MIN_CNT) begin
            state_nx = FCS;
            cnt_nx   = '0;
          end
        end
      end

      FCS: begin
        crc_nx = {4'h0, crc[31:4]};
        if (cnt == 16'd7) begin
          state_nx = POST_FRAME;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      ABORT: begin
        if (cnt == 16'd1) begin
          state_nx = last_q ? POST_FRAME : DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      DRAIN: begin
        if (in_valid && in_last) begin
          state_nx = POST_FRAME;
          cnt_nx   = '0;
        end
      end

      IPG: begin
        if (cnt == IPG_LAST) state_nx = IDLE;
        else                 cnt_nx   = cnt + 16'd1;
      end

      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next-state values so they are registered
  // yet line up with the state occupying the following cycle.
  always_comb begin
    txd_nx      = '0;
    in_ready_nx = 1'b0;
    txen_nx     = 1'b0;
    txer_nx     = (state_nx == ABORT);
    busy_nx     = (state_nx != IDLE);

    unique case (state_nx)
      PREAMBLE: begin
        txen_nx     = 1'b1;
        txd_nx      = (cnt_nx == 16'd15) ? 4'hD : 4'h5;
        in_ready_nx = (cnt_nx == 16'd15);
      end
      PAYLOAD: begin
        txen_nx     = 1'b1;
        txd_nx      = hi_nx ? data_nx[7:4] : data_nx[3:0];
        in_ready_nx = hi_nx && !last_nx && (byte_cnt_nx != MAX_CNT);
      end
      PAD: txen_nx = 1'b1;
      FCS: begin
        txen_nx = 1'b1;
        txd_nx  = ~crc_nx[3:0];
      end
      ABORT: txen_nx = 1'b1;
      DRAIN: in_ready_nx = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed self-checking bench for mii_tx_framer: two instances, one with
// MIN_PAYLOAD=0/MAX_PAYLOAD=16 and one with default sizing.
module tb_mii_tx_framer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] d_i [2];
  logic       v_i [2];
  logic       l_i [2];
  logic       rdy_o [2];
  logic [3:0] txd_o [2];
  logic       txen_o [2];
  logic       txer_o [2];
  logic       busy_o [2];
  logic       fd_o [2];
  logic       fe_o [2];

  mii_tx_framer #(.MIN_PAYLOAD(0), .MAX_PAYLOAD(16), .IPG_CYCLES(24)) dut0 (
    .clk(clk), .reset(reset), .in_data(d_i[0]), .in_valid(v_i[0]), .in_last(l_i[0]),
    .in_ready(rdy_o[0]), .txd(txd_o[0]), .txen(txen_o[0]), .txer(txer_o[0]),
    .busy(busy_o[0]), .frame_done(fd_o[0]), .frame_err(fe_o[0])
  );

  mii_tx_framer #(.MIN_PAYLOAD(60), .MAX_PAYLOAD(1514), .IPG_CYCLES(24)) dut1 (
    .clk(clk), .reset(reset), .in_data(d_i[1]), .in_valid(v_i[1]), .in_last(l_i[1]),
    .in_ready(rdy_o[1]), .txd(txd_o[1]), .txen(txen_o[1]), .txer(txer_o[1]),
    .busy(busy_o[1]), .frame_done(fd_o[1]), .frame_err(fe_o[1])
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] fb [0:63];

  // Per-instance line monitor: nibbles while txen, pulse counts, idle gap.
  logic [3:0] nib [2][0:4095];
  int nib_n [2];
  int txer_cnt [2];
  int done_cnt [2];
  int err_cnt [2];
  int idle_run [2];
  int last_gap [2];
  bit prev_en [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (txen_o[g]) begin
        if (nib_n[g] < 4096) nib[g][nib_n[g]] = txd_o[g];
        nib_n[g]++;
        if (!prev_en[g]) last_gap[g] = idle_run[g];
        idle_run[g] = 0;
      end else begin
        idle_run[g]++;
      end
      if (txer_o[g]) txer_cnt[g]++;
      if (fd_o[g])   done_cnt[g]++;
      if (fe_o[g])   err_cnt[g]++;
      prev_en[g] = txen_o[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input int off, input int n, input bit with_last, input bit hold);
    bit acc;
    int t;
    if (!v_i[k]) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < n; i++) begin
      d_i[k] = fb[off + i];
      l_i[k] = with_last && (i == n - 1);
      v_i[k] = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 500) begin
        @(negedge clk);
        acc = rdy_o[k];
        @(posedge clk);
        #1;
        t++;
      end
      chk($sformatf("hs%0d_byte%0d", k, i), 32'(acc), 32'd1);
    end
    if (!hold) begin
      v_i[k] = 1'b0;
      l_i[k] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy_o[k] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(busy_o[k]), 32'd0);
  endtask

  function automatic logic [31:0] ref_crc(input int off, input int n, input int len);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fbk;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      b = (i < n) ? fb[off + i] : 8'h00;
      for (int j = 0; j < 8; j++) begin
        fbk = c[0] ^ b[j];
        c = c >> 1;
        if (fbk) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic check_frame(input int k, input int base, input int off, input int n,
                             input int minp, input string tag);
    int len;
    int bi;
    logic [31:0] crc;
    logic [7:0]  by;
    logic [3:0]  e;
    len = (n < minp) ? minp : n;
    crc = ref_crc(off, n, len);
    for (int i = 0; i < 16 + 2 * len + 8; i++) begin
      if (i < 15) e = 4'h5;
      else if (i == 15) e = 4'hD;
      else if (i < 16 + 2 * len) begin
        bi = (i - 16) / 2;
        by = (bi < n) ? fb[off + bi] : 8'h00;
        e = ((i - 16) % 2 == 0) ? by[3:0] : by[7:4];
      end else e = crc[4 * (i - 16 - 2 * len) +: 4];
      chk($sformatf("%s_nib%0d", tag, i), 32'(nib[k][base + i]), 32'(e));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, e0, r0, t;
    logic [31:0] f;
    logic [71:0] s;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      d_i[k] = '0;
      v_i[k] = 1'b0;
      l_i[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_outputs%0d", k),
          32'({txd_o[k], txen_o[k], txer_o[k], rdy_o[k], busy_o[k], fd_o[k], fe_o[k]}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // "123456789", no padding: check value 0xCBF43926
    s = "123456789";
    for (int i = 0; i < 9; i++) fb[i] = s[8 * (8 - i) +: 8];
    b0 = nib_n[0]; d0 = done_cnt[0]; e0 = err_cnt[0]; r0 = txer_cnt[0];
    send(0, 0, 9, 1'b1, 1'b0);
    wait_idle(0, "t1_idle");
    chk("t1_txen_cycles", 32'(nib_n[0] - b0), 32'd42);
    chk("t1_done", 32'(done_cnt[0] - d0), 32'd1);
    chk("t1_err", 32'(err_cnt[0] - e0), 32'd0);
    chk("t1_txer", 32'(txer_cnt[0] - r0), 32'd0);
    for (int j = 0; j < 8; j++) f[4 * j +: 4] = nib[0][b0 + 34 + j];
    chk("t1_fcs", f, 32'hCBF4_3926);
    check_frame(0, b0, 0, 9, 0, "t1");

    // single byte padded to 60
    fb[0] = 8'hAB;
    b0 = nib_n[1]; d0 = done_cnt[1];
    send(1, 0, 1, 1'b1, 1'b0);
    wait_idle(1, "t2_idle");
    chk("t2_txen_cycles", 32'(nib_n[1] - b0), 32'd144);
    chk("t2_done", 32'(done_cnt[1] - d0), 32'd1);
    check_frame(1, b0, 0, 1, 60, "t2");

    // underrun after 10 bytes, then drain 3 bytes
    for (int i = 0; i < 13; i++) fb[i] = 8'(i * 7 + 3);
    d0 = done_cnt[1]; e0 = err_cnt[1]; r0 = txer_cnt[1];
    send(1, 0, 10, 1'b0, 1'b0);
    t = 0;
    while (!fe_o[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t3_err_pulse", 32'(fe_o[1]), 32'd1);
    chk("t3_abort0", 32'({txen_o[1], txer_o[1]}), 32'd3);
    @(negedge clk);
    chk("t3_abort1", 32'({txen_o[1], txer_o[1], fe_o[1]}), 32'd6);
    @(negedge clk);
    chk("t3_drain", 32'({txen_o[1], txer_o[1], rdy_o[1], busy_o[1]}), 32'd3);
    send(1, 10, 3, 1'b1, 1'b0);
    t = 0;
    @(negedge clk);
    while (busy_o[1] && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("t3_ipg_len", 32'(t), 32'd24);
    chk("t3_done", 32'(done_cnt[1] - d0), 32'd0);
    chk("t3_err", 32'(err_cnt[1] - e0), 32'd1);
    chk("t3_txer", 32'(txer_cnt[1] - r0), 32'd2);

    // reset in payload cycle 30, then a clean frame
    for (int i = 0; i < 16; i++) fb[i] = 8'(8'hC0 + i);
    send(1, 0, 15, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t4_rst_txen", 32'(txen_o[1]), 32'd0);
    chk("t4_rst_ready", 32'(rdy_o[1]), 32'd0);
    chk("t4_rst_busy", 32'(busy_o[1]), 32'd0);
    v_i[1] = 1'b0;
    l_i[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) fb[i] = 8'(8'h3C ^ (i * 8'h29));
    b0 = nib_n[1]; d0 = done_cnt[1];
    send(1, 0, 5, 1'b1, 1'b0);
    wait_idle(1, "t4_idle");
    chk("t4_txen_cycles", 32'(nib_n[1] - b0), 32'd144);
    chk("t4_done", 32'(done_cnt[1] - d0), 32'd1);
    check_frame(1, b0, 0, 5, 60, "t4");

    // back-to-back frames, in_valid never drops
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
    fb[8] = 8'hDE; fb[9] = 8'hAD; fb[10] = 8'hBE; fb[11] = 8'hEF;
    b0 = nib_n[1]; d0 = done_cnt[1];
    send(1, 0, 3, 1'b1, 1'b1);
    send(1, 8, 4, 1'b1, 1'b0);
    wait_idle(1, "t5_idle");
    chk("t5_gap", 32'(last_gap[1]), 32'd25);
    chk("t5_txen_cycles", 32'(nib_n[1] - b0), 32'd288);
    chk("t5_done", 32'(done_cnt[1] - d0), 32'd2);
    check_frame(1, b0, 0, 3, 60, "t5a");
    check_frame(1, b0 + 144, 8, 4, 60, "t5b");

    // overflow: 20 bytes into MAX_PAYLOAD=16, tail drained
    for (int i = 0; i < 20; i++) fb[i] = 8'(8'h80 + i * 3);
    b0 = nib_n[0]; d0 = done_cnt[0]; e0 = err_cnt[0]; r0 = txer_cnt[0];
    send(0, 0, 20, 1'b1, 1'b0);
    wait_idle(0, "t6_idle");
    chk("t6_txen_cycles", 32'(nib_n[0] - b0), 32'd50);
    chk("t6_err", 32'(err_cnt[0] - e0), 32'd1);
    chk("t6_done", 32'(done_cnt[0] - d0), 32'd0);
    chk("t6_txer", 32'(txer_cnt[0] - r0), 32'd2);

    // exactly MAX_PAYLOAD bytes with in_last on the last one
    b0 = nib_n[0]; d0 = done_cnt[0]; e0 = err_cnt[0];
    send(0, 0, 16, 1'b1, 1'b0);
    wait_idle(0, "t7_idle");
    chk("t7_txen_cycles", 32'(nib_n[0] - b0), 32'd56);
    chk("t7_done", 32'(done_cnt[0] - d0), 32'd1);
    chk("t7_err", 32'(err_cnt[0] - e0), 32'd0);
    check_frame(0, b0, 0, 16, 0, "t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
